alu_seq: RTL and testbench

- Parametrised, registered successor of the single-cycle datapath ALU.
- Keeps the existing 4-bit aluc operation encodings and adds iterative unsigned multiply/divide ops.
- Wraps every operation in a valid/ready handshake so a multi-cycle core (or a stall-capable pipeline EX stage) can issue to it.
- Result and zero flag are registered and held until consumed.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_seq_muldiv.sv | 69 ++++++
 rtl/alu_seq.sv | 94 +++++++++
 tb/tb_alu_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared aluc encodings, FSM state type and op-class helpers for alu_seq.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_LUI   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] aluc);
    return (aluc == ALU_MUL) || (aluc == ALU_MULHU) ||
           (aluc == ALU_DIVU) || (aluc == ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [3:0] aluc);
    return (aluc == ALU_DIVU) || (aluc == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency WIDTH cycles after start; done/result are valid combinationally in the last cycle.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic             run;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi, lo, opd;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // hi/lo hold {product_hi, multiplier} for MUL and {remainder, dividend->quotient} for DIV
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opd};
    diff    = shifted[WIDTH-1:0] - opd;
    if (is_div(op_q)) begin
      hi_n = ge ? diff : shifted[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
    result = ((op_q == ALU_MULHU) || (op_q == ALU_REMU)) ? hi_n : lo_n;
  end

  assign done = run && (cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      run  <= 1'b0;
      cnt  <= '0;
      op_q <= ALU_ADD;
      hi   <= '0;
      lo   <= '0;
      opd  <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      hi   <= '0;
      lo   <= is_div(op) ? a : b;
      opd  <= is_div(op) ? b : a;
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops at T+1, mul/div at T+WIDTH+1.
// Result held in DONE until out_ready; in_ready follows out_ready there for back-to-back issue.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             busy
);

  state_t           state, state_next;
  logic             accept;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_CALC);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_iterative(aluc);
  assign shamt     = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (aluc)
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_XOR: alu_res = a ^ b;
      ALU_LUI: alu_res = b;
      ALU_SLL: alu_res = a << shamt;
      ALU_SRL: alu_res = a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_iterative(aluc) ? ST_CALC : ST_DONE;
      ST_CALC: if (md_done) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = is_iterative(aluc) ? ST_CALC : ST_DONE;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
      s     <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_iterative(aluc)) begin
        s <= alu_res;
        z <= (alu_res == '0);
      end else if ((state == ST_CALC) && md_done) begin
        s <= md_result;
        z <= (md_result == '0);
      end
    end
  end

  alu_seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clock  (clock),
    .resetn (resetn),
    .start  (md_start),
    .op     (aluc),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clock, resetn;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic        out_valid, out_ready;
  logic [31:0] s;
  logic        z, busy;

  typedef struct {
    string       tag;
    logic [31:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .z         (z),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every completed transfer pops one expected result.
  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_s"}, s, mon_e.s);
        chk({mon_e.tag, "_z"}, {31'b0, z}, {31'b0, (mon_e.s == 32'd0)});
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] es, output int t);
    exp_t e;
    int   n;
    n = 0;
    in_valid = 1'b1;
    aluc = op;
    a = x;
    b = y;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk({tag, "_in_ready_timeout"}, {31'b0, in_ready}, 32'd1);
    e.tag = tag;
    e.s = es;
    sb.push_back(e);
    @(posedge clock);
    #1;
    t = cyc;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen; counts busy cycles before it.
  task automatic wait_valid(input string tag, output int tv, output int nb);
    int n;
    nb = 0;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 200) begin
      if (busy) nb++;
      @(negedge clock);
      n++;
    end
    if (!out_valid) chk({tag, "_out_valid_timeout"}, {31'b0, out_valid}, 32'd1);
    tv = cyc;
  endtask

  initial begin
    int t1, t2, tv, nb, n;
    resetn = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    aluc = ALU_ADD;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    @(negedge clock);
    chk("rst_s", s, 32'd0);
    chk("rst_z", {31'b0, z}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clock);
    #1;

    send("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, t1);
    send("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd1);
    send("sra", ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, t1);
    send("sll", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, t1);
    send("srl_hi_ignored", ALU_SRL, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, t1);
    send("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, t1);
    send("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, t1);
    send("undef", 4'b0011, 32'd5, 32'd6, 32'd0, t1);
    send("lui", ALU_LUI, 32'hDEAD_0000, 32'h1234_5678, 32'h1234_5678, t1);
    wait_valid("lui", tv, nb);
    chk("lat_single", 32'(tv - t1 + 1), 32'd1);
    @(posedge clock);
    #1;

    send("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, t1);
    wait_valid("mul", tv, nb);
    chk("lat_mul", 32'(tv - t1 + 1), 32'd33);
    chk("busy_mul", 32'(nb), 32'd32);
    @(posedge clock);
    #1;

    send("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, t1);
    send("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, t1);
    send("divu_0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, t1);
    send("remu_0", ALU_REMU, 32'd9, 32'd0, 32'd9, t1);
    send("mulhu_zero", ALU_MULHU, 32'd0, 32'h0001_2345, 32'd0, t1);
    send("mul_big", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, t1);
    send("mulhu_big", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, t1);

    // Backpressure: junk request held during CALC and DONE must be ignored.
    send("mulhu", ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, t1);
    in_valid = 1'b1;
    aluc = ALU_ADD;
    a = 32'd1;
    b = 32'd2;
    out_ready = 1'b0;
    wait_valid("mulhu", tv, nb);
    chk("busy_mulhu", 32'(nb), 32'd32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_s", s, 32'd1);
      chk("hold_z", {31'b0, z}, 32'd0);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    send("xor", ALU_XOR, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, t1);
    @(posedge clock);
    #1;

    // Reset in the middle of an iterative op.
    send("divu_aborted", ALU_DIVU, 32'd100, 32'd7, 32'd14, t1);
    repeat (5) @(posedge clock);
    #1;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sb.delete();
    @(negedge clock);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_s", s, 32'd0);
    chk("midrst_z", {31'b0, z}, 32'd0);
    @(posedge clock);
    #1;

    send("divu_post_rst", ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, t1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
